// File: rtl/ctrl_pkg.sv
// ctrl_pkg: types and constants shared by the control-word pipeline.
//   - Opcodes of the supported instruction subset (bits 31:26 of the instruction).
//   - ALU-op encodings that the decoder places on id_AOp.
//   - Field groups for each consumer stage (EX, MEM, WB), one stage entry type
//     per pipeline register, and the bubble value of each.
//   - opc_supported(): the opcode screen used in ID.
package ctrl_pkg;

    localparam logic [5:0] OPC_R    = 6'h00;
    localparam logic [5:0] OPC_LW   = 6'h23;
    localparam logic [5:0] OPC_SW   = 6'h2B;
    localparam logic [5:0] OPC_BEQ  = 6'h04;
    localparam logic [5:0] OPC_ADDI = 6'h08;
    localparam logic [5:0] OPC_ANDI = 6'h0C;
    localparam logic [5:0] OPC_ORI  = 6'h0D;
    localparam logic [5:0] OPC_SLTI = 6'h0A;

    localparam logic [2:0] AOP_ADD   = 3'b000;
    localparam logic [2:0] AOP_SUB   = 3'b001;
    localparam logic [2:0] AOP_FUNCT = 3'b010;
    localparam logic [2:0] AOP_ADDI  = 3'b011;
    localparam logic [2:0] AOP_SLTI  = 3'b100;
    localparam logic [2:0] AOP_ANDI  = 3'b101;
    localparam logic [2:0] AOP_ORI   = 3'b110;

    typedef struct packed {
        logic       reg_ds;
        logic       alu_src;
        logic [2:0] aop;
    } ex_ctrl_t;

    typedef struct packed {
        logic branch;
        logic mread;
        logic mwrite;
    } m_ctrl_t;

    typedef struct packed {
        logic mtor;
        logic urw;
    } wb_ctrl_t;

    localparam ex_ctrl_t EX_BUBBLE = '0;
    localparam m_ctrl_t  M_BUBBLE  = '0;
    localparam wb_ctrl_t WB_BUBBLE = '0;

    // Each pipeline register carries only the groups still needed downstream.
    typedef struct packed {
        logic     valid;
        ex_ctrl_t ex;
        m_ctrl_t  m;
        wb_ctrl_t wb;
    } idex_t;

    typedef struct packed {
        logic     valid;
        m_ctrl_t  m;
        wb_ctrl_t wb;
    } exmem_t;

    typedef struct packed {
        logic     valid;
        wb_ctrl_t wb;
    } memwb_t;

    localparam idex_t  IDEX_BUBBLE  = '{valid: 1'b0, ex: EX_BUBBLE, m: M_BUBBLE, wb: WB_BUBBLE};
    localparam exmem_t EXMEM_BUBBLE = '{valid: 1'b0, m: M_BUBBLE, wb: WB_BUBBLE};
    localparam memwb_t MEMWB_BUBBLE = '{valid: 1'b0, wb: WB_BUBBLE};

    // An unknown opcode falls to the default arm, so it is screened as well.
    function automatic logic opc_supported(input logic [5:0] opc);
        logic ok;
        case (opc)
            OPC_R, OPC_LW, OPC_SW, OPC_BEQ,
            OPC_ADDI, OPC_ANDI, OPC_ORI, OPC_SLTI: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ctrl_pipe_stage_reg.sv
// ctrl_stage_reg: one pipeline register for a control-word stage entry.
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   bubble   : when 1, load BUBBLE instead of d on this edge
//   d        : next entry
//   q        : registered entry, equal to BUBBLE while in reset
module ctrl_stage_reg
    import ctrl_pkg::*;
#(
    parameter int           W      = 8,
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    // The select forces a clean constant, so unknown d bits never get stored.
    always_comb begin
        q_d = bubble ? BUBBLE : d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= BUBBLE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decoded control word from ID through ID/EX, EX/MEM and
// MEM/WB, inserting bubbles for stalls, flushes and unsupported opcodes.
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   id_valid, id_*  : decoder outputs for the instruction in ID
//   stall           : replace the ID/EX entry with a bubble
//   flush           : replace the ID/EX and EX/MEM entries with bubbles
//   ex_*, mem_*, wb_*: registered controls for each consumer stage
//   illegal         : one-cycle pulse after an unsupported opcode is screened
//   retired         : count of entries that left WB, wraps at 2^CNT_W
//
// Flow control: each stage entry is qualified only by its valid bit. There is
// no ready; every stage advances on every edge, and stall/flush act solely by
// substituting bubbles (valid=0, all controls 0) into the affected registers.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [5:0]       id_opc,
    input  logic             id_RegDs,
    input  logic             id_Branch,
    input  logic             id_MRead,
    input  logic             id_MtoR,
    input  logic             id_MWrite,
    input  logic             id_ALUsrc,
    input  logic             id_Urw,
    input  logic [2:0]       id_AOp,
    input  logic             stall,
    input  logic             flush,
    output logic             ex_valid,
    output logic             ex_RegDs,
    output logic             ex_ALUsrc,
    output logic [2:0]       ex_AOp,
    output logic             mem_valid,
    output logic             mem_Branch,
    output logic             mem_MRead,
    output logic             mem_MWrite,
    output logic             wb_valid,
    output logic             wb_MtoR,
    output logic             wb_Urw,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    idex_t  idex_d, idex_q;
    exmem_t exmem_d, exmem_q;
    memwb_t memwb_d, memwb_q;

    logic             opc_ok;
    logic             idex_bubble;
    logic             illegal_d, illegal_q;
    logic [CNT_W-1:0] retired_d, retired_q;

    always_comb begin
        opc_ok      = opc_supported(id_opc);
        // flush, stall, empty slot and screened opcode all yield the same bubble.
        idex_bubble = flush | stall | ~id_valid | ~opc_ok;

        idex_d            = IDEX_BUBBLE;
        idex_d.valid      = 1'b1;
        idex_d.ex.reg_ds  = id_RegDs;
        idex_d.ex.alu_src = id_ALUsrc;
        idex_d.ex.aop     = id_AOp;
        idex_d.m.branch   = id_Branch;
        idex_d.m.mread    = id_MRead;
        idex_d.m.mwrite   = id_MWrite;
        idex_d.wb.mtor    = id_MtoR;
        idex_d.wb.urw     = id_Urw;

        exmem_d       = EXMEM_BUBBLE;
        exmem_d.valid = idex_q.valid;
        exmem_d.m     = idex_q.m;
        exmem_d.wb    = idex_q.wb;

        // MEM/WB is never squashed: the branch that triggers a flush retires.
        memwb_d       = MEMWB_BUBBLE;
        memwb_d.valid = exmem_q.valid;
        memwb_d.wb    = exmem_q.wb;

        // A screened opcode is only reported when it would otherwise have issued.
        illegal_d = id_valid & ~stall & ~flush & ~opc_ok;
        retired_d = memwb_q.valid ? retired_q + CNT_W'(1) : retired_q;
    end

    ctrl_stage_reg #(.W($bits(idex_t)), .BUBBLE(IDEX_BUBBLE)) u_idex (
        .clk    (clk),
        .rst    (rst),
        .bubble (idex_bubble),
        .d      (idex_d),
        .q      (idex_q)
    );

    ctrl_stage_reg #(.W($bits(exmem_t)), .BUBBLE(EXMEM_BUBBLE)) u_exmem (
        .clk    (clk),
        .rst    (rst),
        .bubble (flush),
        .d      (exmem_d),
        .q      (exmem_q)
    );

    ctrl_stage_reg #(.W($bits(memwb_t)), .BUBBLE(MEMWB_BUBBLE)) u_memwb (
        .clk    (clk),
        .rst    (rst),
        .bubble (1'b0),
        .d      (memwb_d),
        .q      (memwb_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign ex_valid   = idex_q.valid;
    assign ex_RegDs   = idex_q.ex.reg_ds;
    assign ex_ALUsrc  = idex_q.ex.alu_src;
    assign ex_AOp     = idex_q.ex.aop;
    assign mem_valid  = exmem_q.valid;
    assign mem_Branch = exmem_q.m.branch;
    assign mem_MRead  = exmem_q.m.mread;
    assign mem_MWrite = exmem_q.m.mwrite;
    assign wb_valid   = memwb_q.valid;
    assign wb_MtoR    = memwb_q.wb.mtor;
    assign wb_Urw     = memwb_q.wb.urw;
    assign illegal    = illegal_q;
    assign retired    = retired_q;

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipeline carrier for the decoded control word. Takes the per-instruction control signals produced by the opcode decoder in ID and delivers them, stage by stage, to the EX, MEM and WB consumers. It registers the signals through ID/EX, EX/MEM and MEM/WB and applies stall bubbles and branch flushes. It screens unsupported opcodes so undefined decoder outputs never reach state-changing stages, and counts retired instructions.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  an instruction is present in ID this cycle
- id_opc  in  6  opcode of the ID instruction (bits 31:26)
- id_RegDs, id_Branch, id_MRead, id_MtoR, id_MWrite, id_ALUsrc, id_Urw  in  1 each  decoder outputs
- id_AOp  in  3  decoder ALU-op output
- stall  in  1  hazard stall: insert a bubble into ID/EX
- flush  in  1  taken branch resolved in MEM: squash ID/EX and EX/MEM
- ex_valid, ex_RegDs, ex_ALUsrc  out  1 each  EX-stage controls
- ex_AOp  out  3  EX-stage ALU op
- mem_valid, mem_Branch, mem_MRead, mem_MWrite  out  1 each  MEM-stage controls
- wb_valid, wb_MtoR, wb_Urw  out  1 each  WB-stage controls
- illegal  out  1  one-cycle pulse: an unsupported opcode was screened
- retired  out  CNT_W  count of instructions that left WB

## Operation
- Supported opcodes are 0x00 (R), 0x23 (LW), 0x2B (SW), 0x04 (BEQ), 0x08 (ADDI), 0x0C (ANDI), 0x0D (ORI) and 0x0A (SLTI).
- Bubble: valid=0 and every control bit 0, AOp=000. A bubble never writes a register or memory and never branches.
- ID/EX next value, in priority order:
  - flush=1 → bubble
  - stall=1 → bubble
  - id_valid=0 → bubble
  - opcode unsupported → bubble, and illegal=1 next cycle
  - otherwise the id_* fields with valid=1
- EX/MEM next value: bubble if flush=1, else the ID/EX M-group (Branch, MRead, MWrite) plus valid. In the same entry, WB fields MtoR and Urw are carried along.
- MEM/WB next value: always the EX/MEM WB-group plus valid. There is no squash, so the flushing branch itself retires.
- Only the group relevant to each stage is exposed. Fields are carried internally exactly as far as needed: EX group to ID/EX, M group to EX/MEM, WB group to MEM/WB.
- retired increments by 1 on every rising edge where wb_valid=1. It wraps modulo 2^CNT_W.
- illegal is asserted only when id_valid=1, stall=0 and flush=0.
- Inputs with X values on a screened opcode must not propagate. The outputs are the bubble constants.

## Timing
- All outputs are registered, with no combinational input→output path.
- An instruction accepted at edge n appears on ex_* in cycle n+1, on mem_* in n+2 and on wb_* in n+3.
- illegal rises in the cycle after the screening edge and lasts exactly one cycle unless the next edge screens again.
- stall and flush are sampled on the same edge as the ID data. When both are high, flush wins, and there is no difference in ID/EX content.
- Back-to-back stalls insert one bubble per stalled cycle. Downstream stages keep advancing.
- Reset, async assert: every register is bubble, illegal=0 and retired=0, immediately on assertion without waiting for an edge. On release, the first edge loads normally.
- Reset asserted mid-flight discards all in-flight entries. They are not counted as retired.

## Structure
- Shared package ctrl_pkg holds:
  - opcode constants (OPC_R, OPC_LW, OPC_SW, OPC_BEQ, OPC_ADDI, OPC_ANDI, OPC_ORI, OPC_SLTI)
  - AOp encodings (000 add, 001 sub, 010 funct, 011 addi, 100 slti, 101 andi, 110 ori)
  - packed field-group typedefs ex_ctrl_t, m_ctrl_t, wb_ctrl_t
  - their BUBBLE constants
- One sub-module, ctrl_stage_reg, is a parameterised-width register with async reset to the bubble value and a bubble-select input. It is instantiated three times.
- The opcode screen and the counter live in the top.

## Test plan
- Reset, then LW (0x23) for one cycle: the bench must see the fields arrive on the edges given in the bullets below.
  - n+1: ex_valid=1, ex_AOp=000, ex_ALUsrc=1
  - n+2: mem_MRead=1
  - n+3: wb_MtoR=1, wb_Urw=1
  - retired=1 after n+4
- Opcode 0x3F with id_valid=1 and all id_* driven X → illegal=1 for one cycle. All stage outputs stay 0 for three cycles and retired is unchanged.
- SW then BEQ then ADDI, with stall=1 on the BEQ cycle only → ex_* shows SW, bubble, BEQ, ADDI. BEQ is re-presented by the bench. mem_MWrite=1 occurs only once.
- R, ORI and SLTI in consecutive cycles, then flush=1 as R reaches MEM → ORI and SLTI are squashed. Only R reaches WB with wb_Urw=1, and retired increases by 1.
- stall=1 and flush=1 together with an unsupported opcode → bubble inserted and illegal stays 0.
- Stream 10 valid R instructions and assert rst asynchronously mid-cycle during the 6th → all outputs 0 before the next edge and retired=0. After release, 3 LWs give retired=3.
